dma_descriptor_sequencer: RTL

//  Upstream of the DMA engine: CPU queues {src,dst,len} descriptors here. The

---
 rtl/dma_descriptor_sequencer.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/dma_descriptor_sequencer.sv
// Descriptor sequencer: queues CPU-written {src,dst,len} triplets and programs
// the DMA control slave for each one, waiting for a done edge or a timeout.
module dma_descriptor_sequencer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 65535
) (
  input  logic        iClk,
  input  logic        iReset_n,
  input  logic        iChipselect_n,
  input  logic        iRead,
  input  logic        iWrite,
  input  logic [2:0]  iAddress,
  input  logic [31:0] iWritedata,
  output logic [31:0] oReaddata,
  output logic        oIrq,
  output logic        oDM_chipselect_n,
  output logic        oDM_write,
  output logic [2:0]  oDM_address,
  output logic [31:0] oDM_writedata,
  input  logic        iDM_done
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_SRC, S_DST, S_LEN, S_GO, S_WAIT} state_t;
  state_t r_state, w_state_nxt;

  logic [DEPTH-1:0][31:0] r_q_src, r_q_dst, r_q_len;
  logic [AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count, w_count_nxt;
  logic [31:0]   r_src, r_dst, r_len, r_readdata, w_rd_mux;
  logic [31:0]   w_head_src, w_head_dst, w_head_len;
  logic [15:0]   r_completed;
  logic [TW-1:0] r_timer;
  logic r_run, r_irq_en, r_ovf, r_irq, r_tmo_err, r_done_q;
  logic w_cpu_wr, w_cpu_rd, w_sts_wr, w_push_req, w_push, w_pop, w_full, w_empty;
  logic w_done_rise, w_tmo, w_zero_pop, w_cmpl_inc;

  always_comb begin
    w_cpu_wr    = ~iChipselect_n & iWrite;
    w_cpu_rd    = ~iChipselect_n & iRead;
    w_sts_wr    = w_cpu_wr & (iAddress == 3'd4);
    w_full      = (r_count == CW'(DEPTH));
    w_empty     = (r_count == '0);
    w_push_req  = w_cpu_wr & (iAddress == 3'd3);
    w_push      = w_push_req & ~w_full;
    w_head_src  = r_q_src[r_rptr];
    w_head_dst  = r_q_dst[r_rptr];
    w_head_len  = r_q_len[r_rptr];
    // a done level already high when WAIT starts is not a completion
    w_done_rise = iDM_done & ~r_done_q;
    w_tmo       = (r_state == S_WAIT) & ~w_done_rise & (r_timer == TW'(TIMEOUT - 1));
    w_zero_pop  = (r_state == S_IDLE) & r_run & ~w_empty & (w_head_len == '0);
    w_pop       = w_zero_pop | ((r_state == S_WAIT) & (w_done_rise | w_tmo));
    w_cmpl_inc  = w_pop & ~w_tmo;
    w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
  end

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      r_q_src <= '0; r_q_dst <= '0; r_q_len <= '0;
      r_wptr  <= '0; r_rptr  <= '0; r_count <= '0;
    end else begin
      if (w_push) begin
        r_q_src[r_wptr] <= r_src;
        r_q_dst[r_wptr] <= r_dst;
        r_q_len[r_wptr] <= r_len;
        r_wptr          <= r_wptr + AW'(1);
      end
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      r_count <= w_count_nxt;
    end
  end

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      r_src <= '0; r_dst <= '0; r_len <= '0; r_run <= 1'b0; r_irq_en <= 1'b0;
      r_ovf <= 1'b0; r_irq <= 1'b0; r_tmo_err <= 1'b0; r_completed <= '0;
      r_done_q <= 1'b0; r_timer <= '0; r_readdata <= '0;
    end else begin
      if (w_cpu_wr && iAddress == 3'd0) r_src <= iWritedata;
      if (w_cpu_wr && iAddress == 3'd1) r_dst <= iWritedata;
      if (w_cpu_wr && iAddress == 3'd2) r_len <= iWritedata;
      if (w_cpu_wr && iAddress == 3'd5) {r_irq_en, r_run} <= iWritedata[1:0];
      // sticky bits: a clear write beats a set in the same cycle
      if (w_sts_wr && iWritedata[3])       r_ovf <= 1'b0;
      else if (w_push_req && w_full)       r_ovf <= 1'b1;
      if (w_sts_wr && iWritedata[4])       r_irq <= 1'b0;
      else if (w_pop && w_count_nxt == '0 && r_irq_en) r_irq <= 1'b1;
      if (w_sts_wr && iWritedata[5])       r_tmo_err <= 1'b0;
      else if (w_tmo)                      r_tmo_err <= 1'b1;
      if (w_cmpl_inc) r_completed <= r_completed + 16'd1;
      r_done_q   <= iDM_done;
      r_timer    <= (r_state == S_WAIT) ? r_timer + TW'(1) : '0;
      r_readdata <= w_cpu_rd ? w_rd_mux : '0;
    end
  end

  always_comb begin
    w_rd_mux = '0;
    case (iAddress)
      3'd0: w_rd_mux = r_src;
      3'd1: w_rd_mux = r_dst;
      3'd2: w_rd_mux = r_len;
      3'd4: w_rd_mux = {r_completed, 4'b0, 4'(r_count), 2'b0, r_tmo_err, r_irq,
                        r_ovf, w_empty, w_full, (r_state != S_IDLE)};
      3'd5: w_rd_mux = {30'b0, r_irq_en, r_run};
      default: w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) r_state <= S_IDLE;
    else           r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (r_run && !w_empty && w_head_len != '0) w_state_nxt = S_SRC;
      S_SRC:  w_state_nxt = S_DST;
      S_DST:  w_state_nxt = S_LEN;
      S_LEN:  w_state_nxt = S_GO;
      S_GO:   w_state_nxt = S_WAIT;
      S_WAIT: if (w_done_rise || w_tmo) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // bus strobes decode straight from state so an async reset drops them at once
  always_comb begin
    oDM_chipselect_n = 1'b1;
    oDM_write        = 1'b0;
    oDM_address      = 3'd0;
    oDM_writedata    = '0;
    case (r_state)
      S_SRC: begin oDM_chipselect_n = 1'b0; oDM_write = 1'b1; oDM_address = 3'd0; oDM_writedata = w_head_src; end
      S_DST: begin oDM_chipselect_n = 1'b0; oDM_write = 1'b1; oDM_address = 3'd1; oDM_writedata = w_head_dst; end
      S_LEN: begin oDM_chipselect_n = 1'b0; oDM_write = 1'b1; oDM_address = 3'd2; oDM_writedata = w_head_len; end
      S_GO:  begin oDM_chipselect_n = 1'b0; oDM_write = 1'b1; oDM_address = 3'd3; oDM_writedata = 32'd1; end
      default: ;
    endcase
  end

  assign oReaddata = r_readdata;
  assign oIrq      = r_irq;
endmodule
